// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_reg
//  Description : Execute -> memory-access pipeline register for the 5-stage
//                MIPS32 core. Carries the GPR/HI-LO write results and the
//                intermediate product/cycle count of two-cycle MADD/MSUB ops.
//                Implements reset, flush, bubble, advance and hold behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [5:0]  stall,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    localparam logic [4:0]  c_NOP_REG  = 5'd0;
    localparam logic [31:0] c_ZERO_32  = 32'd0;
    localparam logic [63:0] c_ZERO_64  = 64'd0;
    localparam logic [1:0]  c_ZERO_CNT = 2'd0;

    // Only the execute and memory stall bits matter to this stage.
    logic w_ex_stall;
    logic w_mem_stall;
    logic w_clear;

    assign w_ex_stall  = stall[3];
    assign w_mem_stall = stall[4];
    // Reset and flush produce identical state, so they share one path.
    assign w_clear     = rst | flush;

    logic [4:0]  r_wd;
    logic        r_wreg;
    logic [31:0] r_wdata;
    logic        r_whilo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_hilo;
    logic [1:0]  r_cnt;

    // Pipeline register update: clear > bubble > advance > hold.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wd    <= c_NOP_REG;
            r_wreg  <= 1'b0;
            r_wdata <= c_ZERO_32;
            r_whilo <= 1'b0;
            r_hi    <= c_ZERO_32;
            r_lo    <= c_ZERO_32;
            r_hilo  <= c_ZERO_64;
            r_cnt   <= c_ZERO_CNT;
        end else if (w_ex_stall && !w_mem_stall) begin
            // Bubble: a NOP goes to memory while execute keeps its
            // first-cycle product alive through the feedback path.
            r_wd    <= c_NOP_REG;
            r_wreg  <= 1'b0;
            r_wdata <= c_ZERO_32;
            r_whilo <= 1'b0;
            r_hi    <= c_ZERO_32;
            r_lo    <= c_ZERO_32;
            r_hilo  <= hilo_i;
            r_cnt   <= cnt_i;
        end else if (!w_ex_stall) begin
            // Advance: the execute result moves on and any multi-cycle
            // accumulate state is finished with.
            r_wd    <= ex_wd;
            r_wreg  <= ex_wreg;
            r_wdata <= ex_wdata;
            r_whilo <= ex_whilo;
            r_hi    <= ex_hi;
            r_lo    <= ex_lo;
            r_hilo  <= c_ZERO_64;
            r_cnt   <= c_ZERO_CNT;
        end
        // Both stages stalled: every register holds.
    end

    assign mem_wd    = r_wd;
    assign mem_wreg  = r_wreg;
    assign mem_wdata = r_wdata;
    assign mem_whilo = r_whilo;
    assign mem_hi    = r_hi;
    assign mem_lo    = r_lo;
    assign hilo_o    = r_hilo;
    assign cnt_o     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_reg
//  Description : Self-checking bench for ex_mem_reg: directed scenarios plus
//                randomized traffic compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    ex_mem_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .ex_whilo  (ex_whilo),
        .ex_hi     (ex_hi),
        .ex_lo     (ex_lo),
        .hilo_i    (hilo_i),
        .cnt_i     (cnt_i),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_whilo (mem_whilo),
        .mem_hi    (mem_hi),
        .mem_lo    (mem_lo),
        .hilo_o    (hilo_o),
        .cnt_o     (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected register contents: the memory-stage entry plus the feedback.
    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } state_t;

    state_t m;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic state_t zero_state();
        state_t s;
        s.wd = '0; s.wreg = 1'b0; s.wdata = '0; s.whilo = 1'b0;
        s.hi = '0; s.lo = '0; s.hilo = '0; s.cnt = '0;
        return s;
    endfunction

    // Behavioural reference: decide what the stage does this cycle, then
    // apply that decision to the expected state.
    task automatic model_update();
        state_t nxt;
        nxt = m;
        if (rst || flush) begin
            nxt = zero_state();
        end else if (!stall[3]) begin
            nxt.wd = ex_wd; nxt.wreg = ex_wreg; nxt.wdata = ex_wdata;
            nxt.whilo = ex_whilo; nxt.hi = ex_hi; nxt.lo = ex_lo;
            nxt.hilo = '0; nxt.cnt = '0;
        end else if (!stall[4]) begin
            nxt = zero_state();
            nxt.hilo = hilo_i;
            nxt.cnt  = cnt_i;
        end
        m = nxt;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".mem_wd"},    64'(mem_wd),    64'(m.wd));
        chk({ctx, ".mem_wreg"},  64'(mem_wreg),  64'(m.wreg));
        chk({ctx, ".mem_wdata"}, 64'(mem_wdata), 64'(m.wdata));
        chk({ctx, ".mem_whilo"}, 64'(mem_whilo), 64'(m.whilo));
        chk({ctx, ".mem_hi"},    64'(mem_hi),    64'(m.hi));
        chk({ctx, ".mem_lo"},    64'(mem_lo),    64'(m.lo));
        chk({ctx, ".hilo_o"},    hilo_o,         m.hilo);
        chk({ctx, ".cnt_o"},     64'(cnt_o),     64'(m.cnt));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick(input string ctx);
        @(posedge clk);
        model_update();
        #1;
        check_all(ctx);
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_whilo = whilo; ex_hi = hi; ex_lo = lo;
    endtask

    task automatic randomize_inputs();
        set_ex(5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom);
        hilo_i = {$urandom, $urandom};
        cnt_i  = 2'($urandom);
    endtask

    initial begin
        m = zero_state();
        // Reset with every input at a nonzero pattern.
        rst = 1'b1; flush = 1'b0; stall = 6'b111111;
        set_ex(5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
        hilo_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'd3;
        stall = 6'b000000;
        for (int i = 0; i < 2; i++) begin
            tick("reset");
            chk("reset.hilo_zero", hilo_o, 64'd0);
        end
        rst = 1'b0;

        // Advance.
        stall = 6'b000000;
        set_ex(5'd8, 1'b1, 32'h1234_5678, 1'b1, 32'hA, 32'hB);
        tick("advance");
        chk("advance.wdata_const", 64'(mem_wdata), 64'h1234_5678);
        chk("advance.wd_const",    64'(mem_wd),    64'd8);

        // Bubble for 3 cycles after a valid entry.
        stall  = 6'b001111;
        hilo_i = 64'hDEAD_BEEF_0000_0001; cnt_i = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick("bubble");
            chk("bubble.wreg_const", 64'(mem_wreg), 64'd0);
            chk("bubble.hilo_const", hilo_o, 64'hDEAD_BEEF_0000_0001);
        end

        // Hold for 4 cycles while inputs churn.
        stall = 6'b000000;
        set_ex(5'd3, 1'b1, 32'h55, 1'b0, 32'h0, 32'h0);
        tick("hold_load");
        stall = 6'b011111;
        for (int i = 0; i < 4; i++) begin
            randomize_inputs();
            tick("hold");
            chk("hold.wdata_const", 64'(mem_wdata), 64'h55);
        end

        // Two-cycle MADD.
        stall = 6'b001000; cnt_i = 2'd1; hilo_i = 64'h1_0000_0002;
        tick("madd1");
        chk("madd1.hilo_const", hilo_o, 64'h1_0000_0002);
        chk("madd1.cnt_const",  64'(cnt_o), 64'd1);
        stall = 6'b000000;
        set_ex(5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h5);
        tick("madd2");
        chk("madd2.lo_const",   64'(mem_lo), 64'd5);
        chk("madd2.hilo_const", hilo_o, 64'd0);

        // Flush during a stalled MADD.
        stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'h0000_0007_0000_0009;
        tick("flush_pre");
        stall = 6'b011111;
        tick("flush_hold");
        chk("flush_hold.cnt_const", 64'(cnt_o), 64'd1);
        flush = 1'b1;
        tick("flush");
        chk("flush.cnt_const",  64'(cnt_o), 64'd0);
        chk("flush.hilo_const", hilo_o, 64'd0);
        flush = 1'b0;

        // Randomized traffic, rare reset/flush, all stall bit patterns.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            rst   = ($urandom_range(0, 29) == 0);
            flush = ($urandom_range(0, 19) == 0);
            stall = 6'($urandom);
            tick("random");
        end
        rst = 1'b0; flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mem_reg.md
# ex_mem_reg

Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 core. It latches the execute results: destination register, write enable, write data, and the HI/LO write request. On the rising edge these are presented to the memory stage as its `*_i` inputs. It implements the pipeline stall/bubble rules and a flush. It also carries the intermediate 64-bit product and cycle counter that two-cycle MADD/MADDU/MSUB/MSUBU instructions need while the execute stage is stalled on them.

## Interface
Parameters:
- none. Widths are fixed: register address 5 bits, register data 32 bits, double data 64 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  exception flush; turns the next stored entry into a NOP
- stall  in  6  pipeline stall vector; bit 3 = execute stalled, bit 4 = memory stalled
- ex_wd  in  5  destination register address from execute
- ex_wreg  in  1  GPR write enable from execute
- ex_wdata  in  32  GPR write data from execute
- ex_whilo  in  1  HI/LO write enable from execute
- ex_hi  in  32  HI write value
- ex_lo  in  32  LO write value
- hilo_i  in  64  partial product/accumulator from execute (multi-cycle accumulate)
- cnt_i  in  2  accumulate cycle count from execute
- mem_wd  out  5  to memory stage
- mem_wreg  out  1  to memory stage
- mem_wdata  out  32  to memory stage
- mem_whilo  out  1  to memory stage
- mem_hi  out  32  to memory stage
- mem_lo  out  32  to memory stage
- hilo_o  out  64  partial product fed back to execute
- cnt_o  out  2  cycle count fed back to execute

## Operation
- All outputs are registered and update only on the rising clk edge. There is no combinational path from inputs to outputs.
- Each edge is evaluated in this priority order:
  1. rst=1: all outputs cleared. mem_wd=5'b0 (NOP address), mem_wreg=0, mem_wdata=0, mem_whilo=0, mem_hi=0, mem_lo=0, hilo_o=0, cnt_o=0.
  2. flush=1: same values as reset. This applies regardless of stall.
  3. stall[3]=1 and stall[4]=0 (bubble): the six mem_* outputs take the reset/NOP values. hilo_o<=hilo_i and cnt_o<=cnt_i, so execute recovers its first-cycle product on the next cycle.
  4. stall[3]=0 (advance): the six mem_* outputs load the corresponding ex_* inputs. hilo_o<=0 and cnt_o<=0.
  5. Otherwise (stall[3]=1 and stall[4]=1, hold): every output keeps its value, including hilo_o and cnt_o.
- stall[4]=1 with stall[3]=0 cannot occur, because the controller always stalls earlier stages too. If it does occur, rule 4 applies.
- stall bits 0–2 and 5 are ignored.
- Values are stored exactly as presented, with no arithmetic or width conversion. Only HI/LO and the GPR write bits qualified by the enables have meaning downstream. Data are stored even when the enables are 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N and remain stable until edge N+1.
- During a bubble, a NOP enters memory on each cycle that execute is stalled. The execute instruction itself is not lost, because execute holds its inputs.
- Two-cycle MADD sequence:
  - Cycle 1: execute stalls with cnt_i=1 and hilo_i=product. At the edge, hilo_o and cnt_o capture these values.
  - Cycle 2: execute reads hilo_o/cnt_o=1, completes, and deasserts stall[3]. At the edge, the result advances and hilo_o/cnt_o clear to 0.
- A reset or flush in the middle of a MADD sequence clears hilo_o and cnt_o. The aborted instruction leaves no state.
- When rst and flush are asserted together, the reset values result, which are identical to the flush values.

## Test plan
- Reset: assert rst for 2 cycles with all inputs at nonzero patterns -> every output reads 0 after the first edge and stays 0.
- Advance: stall=0, ex_wd=5'd8, ex_wreg=1, ex_wdata=32'h1234_5678, ex_whilo=1, ex_hi=32'hA, ex_lo=32'hB -> on the next cycle mem_* equal these values, and hilo_o=0, cnt_o=0.
- Bubble: a valid entry is latched, then stall=6'b001111 for 3 cycles with hilo_i=64'hDEAD_BEEF_0000_0001 and cnt_i=1 -> mem_wreg=0, mem_wd=0, mem_whilo=0 each cycle; hilo_o=64'hDEAD_BEEF_0000_0001 and cnt_o=1.
- Hold: a valid entry with ex_wdata=32'h55 is latched, then stall=6'b011111 for 4 cycles while the inputs change -> all outputs stay fixed, with mem_wdata=32'h55 throughout.
- MADD: cycle 1 has stall[3]=1, cnt_i=1, hilo_i=64'h1_0000_0002; cycle 2 has stall=0, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h5 -> hilo_o=64'h1_0000_0002 after edge 1; then mem_whilo=1, mem_hi=1, mem_lo=5, hilo_o=0, cnt_o=0 after edge 2.
- Flush during a stalled MADD: cnt_o=1 with stall=6'b011111, then flush=1 for 1 cycle -> all outputs are 0 after that edge.
